// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event controller: per-channel synchroniser and edge
// detector feeding a one-deep pending slot, drained round-robin into a single
// registered valid/ready event stream.

// Per-channel lane: synchroniser, edge detect, pending slot, sticky overflow.
module edge_event_chan #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  input  logic i_rise_en,
  input  logic i_fall_en,
  input  logic i_grant,
  input  logic i_ovf_clr,
  output logic o_pend,
  output logic o_typ,
  output logic o_ovf
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_prev, r_pend, r_typ, r_ovf;
  logic w_s, w_rise, w_fall, w_edge;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev & i_rise_en;
  assign w_fall = ~w_s & r_prev & i_fall_en;
  assign w_edge = w_rise | w_fall;

  // Synchronise the async line and remember the previous synchronised level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_s;
    end
  end

  // Slot refills in the same cycle it is granted, so a grant never loses an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= 1'b0;
      r_typ  <= 1'b0;
    end else if (w_edge && (!r_pend || i_grant)) begin
      r_pend <= 1'b1;
      r_typ  <= w_rise;
    end else if (i_grant) begin
      r_pend <= 1'b0;
    end
  end

  // Sticky overflow; a fresh drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              r_ovf <= 1'b0;
    else if (w_edge && r_pend && !i_grant) r_ovf <= 1'b1;
    else if (i_ovf_clr)                    r_ovf <= 1'b0;
  end

  assign o_pend = r_pend;
  assign o_typ  = r_typ;
  assign o_ovf  = r_ovf;
endmodule

module edge_event_arbiter #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          d_in,
  input  logic [NCH-1:0]          rise_en,
  input  logic [NCH-1:0]          fall_en,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(NCH)-1:0]  evt_ch,
  output logic                    evt_rise,
  output logic [NCH-1:0]          ovf,
  input  logic                    ovf_clr
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0] w_pend, w_typ, w_gnt;
  logic           w_free, w_any;
  logic [CW-1:0]  w_idx;
  logic [CW-1:0]  r_last, r_ch;
  logic           r_valid, r_rise;

  // Output register can take a new event when empty or being consumed.
  assign w_free = ~r_valid | evt_ready;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_chan
      assign w_gnt[g] = w_free & w_any & (w_idx == CW'(g));
      edge_event_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
        .clk      (clk),
        .rst      (rst),
        .i_d      (d_in[g]),
        .i_rise_en(rise_en[g]),
        .i_fall_en(fall_en[g]),
        .i_grant  (w_gnt[g]),
        .i_ovf_clr(ovf_clr),
        .o_pend   (w_pend[g]),
        .o_typ    (w_typ[g]),
        .o_ovf    (ovf[g])
      );
    end
  endgenerate

  // Round-robin pick: scan offsets high to low so offset 1 (just after last grant) wins.
  always_comb begin
    logic [CW-1:0] cand;
    w_any = 1'b0;
    w_idx = '0;
    cand  = '0;
    for (int off = NCH; off >= 1; off--) begin
      cand = CW'((int'(r_last) + off) % NCH);
      if (w_pend[cand]) begin
        w_any = 1'b1;
        w_idx = cand;
      end
    end
  end

  // Present the granted event; hold everything stable under backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_rise  <= 1'b0;
      r_last  <= CW'(NCH-1);
    end else if (w_free) begin
      if (w_any) begin
        r_valid <= 1'b1;
        r_ch    <= w_idx;
        r_rise  <= w_typ[w_idx];
        r_last  <= w_idx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign evt_valid = r_valid;
  assign evt_ch    = r_ch;
  assign evt_rise  = r_rise;
endmodule
